sorted_vector_streamer: RTL and testbench
=========================================

Name: sorted_vector_streamer

Overview:
- Consumes one packed, ascending-sorted vector of N keys produced by the odd-even merge network.
- Streams the keys out one per beat over a valid/ready interface, in ascending or descending order.
- Sits between the 4-key merge stage and the serial V2V message formatter.
- Also checks that each accepted vector is sorted, as an integrity hook for the merge network.

Parameters:
- WIDTH, 4, bit width of one key (unsigned).
- N, 4, keys per packed vector; must be at least 2. The index counter is clog2(N) bits wide.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*WIDTH  packed vector; slot k occupies bits [(k+1)*WIDTH-1 : k*WIDTH]; slot 0 holds the smallest key.
- in_desc  input  1  order for this vector: 0 streams slot 0 first, 1 streams slot N-1 first; sampled with in_data.
- in_valid  input  1  in_data and in_desc are valid.
- in_ready  output  1  the block can accept a vector this cycle.
- out_data  output  WIDTH  current key.
- out_last  output  1  marks the final key of the current vector.
- out_valid  output  1  out_data and out_last are valid.
- out_ready  input  1  downstream accepts this beat.
- order_err  output  1  sticky flag: an accepted vector was not non-decreasing.
- clr_err  input  1  synchronous clear of order_err.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, idx=0, buffer=0, desc_q=0, out_valid=0, out_data=0, out_last=0, order_err=0. Reset during streaming discards the vector in flight; no partial beats are issued afterwards.
- States:
  - IDLE: no vector held.
  - SEND: vector held, beats being issued.
- in_ready is combinational: 1 in IDLE, or in SEND when (out_valid & out_ready & idx==N-1). This allows back-to-back vectors with no bubble.
- Load: when in_valid & in_ready, capture in_data into the buffer and in_desc into desc_q, set idx=0, next state=SEND. Latency from load edge to first out_valid=1 is 1 cycle.
- Outputs are registered from buffer, idx and desc_q:
  - out_data = slot idx when desc_q=0, slot N-1-idx when desc_q=1.
  - out_last = (idx==N-1).
  - out_valid = (state==SEND).
- Beat transfer: out_valid & out_ready.
  - If idx<N-1: idx increments.
  - If idx==N-1 and a load occurs the same cycle: reload, stay in SEND, idx=0.
  - If idx==N-1 and no load: go to IDLE, out_valid drops the next cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and idx hold stable.
- in_valid while in_ready=0 is ignored; the upstream source must hold its data.
- Sort check: at each load, if any slot k+1 < slot k (unsigned compare), set order_err the next cycle. The vector is still streamed unchanged. Equal keys are legal.
- order_err stays set until clr_err=1. If clr_err and a new error coincide, set wins.
- Throughput: exactly N beats per vector, with zero stall when out_ready is held at 1.

Test Plan:
- Reset, then load in_data={4'd9,4'd7,4'd3,4'd1} (slot3..slot0), in_desc=0, out_ready=1 -> out_data 1,3,7,9 on four consecutive cycles starting 1 cycle after load; out_last=1 only with 9; order_err=0.
- Same vector with in_desc=1 -> out_data 9,7,3,1; out_last with 1.
- Back-to-back: second vector {8,8,2,0} with in_valid held; in_ready=1 in the cycle of beat 9 -> eight contiguous beats 1,3,7,9,0,2,8,8 with no bubble.
- Backpressure: drop out_ready for 3 cycles at beat 2 -> out_data holds 3 with out_valid=1 for 3 cycles; in_ready=0 throughout; the stream then resumes with 7,9.
- Unsorted input {1,9,3,7} -> beats 7,3,9,1 still streamed; order_err=1 the cycle after load. Pulse clr_err -> order_err=0. Clear coinciding with a new bad load -> order_err stays 1.
- Assert rst_n=0 after beat 2 -> out_valid=0 and order_err=0 immediately; in_ready=1 after release; the next vector streams from its first key.

Source files
------------

// File: rtl/sorted_vector_streamer.sv
// Streams a sorted packed key vector one key per beat, ascending or descending,
// and flags any accepted vector that is not non-decreasing.
module sorted_vector_streamer #(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_desc,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               order_err,
    input  logic               clr_err
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n, sel;
    logic [N*WIDTH-1:0] buffer, buf_n;
    logic               desc_q, desc_n;
    logic               beat, at_last, load, bad;

    assign beat     = out_valid & out_ready;
    assign at_last  = (idx == LAST);
    assign in_ready = (state == IDLE) | (beat & at_last);
    assign load     = in_valid & in_ready;

    always_comb begin
        bad = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (in_data[(k+1)*WIDTH +: WIDTH] < in_data[k*WIDTH +: WIDTH])
                bad = 1'b1;
        end
    end

    // Outputs are registered, so they are derived from next-cycle state.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        buf_n   = buffer;
        desc_n  = desc_q;
        if (load) begin
            state_n = SEND;
            idx_n   = '0;
            buf_n   = in_data;
            desc_n  = in_desc;
        end else if (beat) begin
            if (at_last)
                state_n = IDLE;
            else
                idx_n = idx + 1'b1;
        end
        sel = desc_n ? (LAST - idx_n) : idx_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            buffer    <= '0;
            desc_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            order_err <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            buffer    <= buf_n;
            desc_q    <= desc_n;
            out_valid <= (state_n == SEND);
            out_data  <= buf_n[int'(sel)*WIDTH +: WIDTH];
            out_last  <= (idx_n == LAST);
            if (load && bad)
                order_err <= 1'b1;
            else if (clr_err)
                order_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sorted_vector_streamer.sv
// Directed bench for sorted_vector_streamer: order, back-to-back,
// backpressure, sort check and mid-stream reset.
module tb_sorted_vector_streamer;
    localparam int WIDTH = 4;
    localparam int N     = 4;

    logic               clk = 0;
    logic               rst_n;
    logic [N*WIDTH-1:0] in_data;
    logic               in_desc;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
    logic               order_err;
    logic               clr_err;

    int tests = 0;
    int fails = 0;

    localparam logic [15:0] V1  = 16'h9731;
    localparam logic [15:0] V2  = 16'h8820;
    localparam logic [15:0] BAD = 16'h1937;

    sorted_vector_streamer #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_desc(in_desc),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .order_err(order_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 0; in_data = '0; in_desc = 0; in_valid = 0;
        out_ready = 0; clr_err = 0;
        tick; tick;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_valid got %b want 0", out_valid);
        end
        tests++;
        if (out_data !== 4'd0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL rst_data got %0d/%b want 0/0", out_data, out_last);
        end
        tests++;
        if (order_err !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_flags got err=%b rdy=%b want 0/1", order_err, in_ready);
        end
        rst_n = 1;
        tick;
    endtask

    task automatic test_ascending;
        logic [3:0] exp [4] = '{4'd1, 4'd3, 4'd7, 4'd9};
        in_data = V1; in_desc = 0; in_valid = 1; out_ready = 1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL asc_ready got %b want 1", in_ready);
        end
        tick;
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3)) begin
                fails++;
                $display("FAIL asc_beat%0d got v=%b d=%0d l=%b want 1/%0d/%b",
                         i, out_valid, out_data, out_last, exp[i], (i == 3));
            end
            tick;
        end
        tests++;
        if (out_valid !== 1'b0 || order_err !== 1'b0) begin
            fails++;
            $display("FAIL asc_end got v=%b err=%b want 0/0", out_valid, order_err);
        end
    endtask

    task automatic test_descending;
        logic [3:0] exp [4] = '{4'd9, 4'd7, 4'd3, 4'd1};
        in_data = V1; in_desc = 1; in_valid = 1; out_ready = 1;
        tick;
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3)) begin
                fails++;
                $display("FAIL desc_beat%0d got v=%b d=%0d l=%b want 1/%0d/%b",
                         i, out_valid, out_data, out_last, exp[i], (i == 3));
            end
            tick;
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL desc_end got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp [8] = '{1, 3, 7, 9, 0, 2, 8, 8};
        in_data = V1; in_desc = 0; in_valid = 1; out_ready = 1;
        tick;
        in_data = V2;
        #1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i % 4 == 3)) begin
                fails++;
                $display("FAIL b2b_beat%0d got v=%b d=%0d l=%b want 1/%0d/%b",
                         i, out_valid, out_data, out_last, exp[i], (i % 4 == 3));
            end
            if (i < 4) begin
                tests++;
                if (in_ready !== (i == 3)) begin
                    fails++;
                    $display("FAIL b2b_ready%0d got %b want %b", i, in_ready, (i == 3));
                end
            end
            tick;
            if (i == 3) in_valid = 0;
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        in_data = V1; in_desc = 0; in_valid = 1; out_ready = 1;
        tick;
        in_valid = 0;
        tick;
        for (int j = 0; j < 3; j++) begin
            out_ready = 0;
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== 4'd3 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d got v=%b d=%0d r=%b want 1/3/0",
                         j, out_valid, out_data, in_ready);
            end
            tick;
        end
        out_ready = 1;
        tick;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 4'd7 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL bp_resume7 got v=%b d=%0d l=%b want 1/7/0",
                     out_valid, out_data, out_last);
        end
        tick;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 4'd9 || out_last !== 1'b1) begin
            fails++;
            $display("FAIL bp_resume9 got v=%b d=%0d l=%b want 1/9/1",
                     out_valid, out_data, out_last);
        end
        tick;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_end got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_sort_check;
        logic [3:0] exp [4] = '{4'd7, 4'd3, 4'd9, 4'd1};
        in_data = BAD; in_desc = 0; in_valid = 1; out_ready = 1;
        tick;
        in_valid = 0;
        tests++;
        if (order_err !== 1'b1) begin
            fails++;
            $display("FAIL sort_set got %b want 1", order_err);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                fails++;
                $display("FAIL sort_beat%0d got v=%b d=%0d want 1/%0d",
                         i, out_valid, out_data, exp[i]);
            end
            tick;
        end
        tests++;
        if (order_err !== 1'b1) begin
            fails++;
            $display("FAIL sort_sticky got %b want 1", order_err);
        end
        clr_err = 1;
        tick;
        clr_err = 0;
        tests++;
        if (order_err !== 1'b0) begin
            fails++;
            $display("FAIL sort_clear got %b want 0", order_err);
        end
        in_data = BAD; in_valid = 1; clr_err = 1;
        tick;
        in_valid = 0; clr_err = 0;
        tests++;
        if (order_err !== 1'b1) begin
            fails++;
            $display("FAIL sort_setwins got %b want 1", order_err);
        end
        repeat (4) tick;
    endtask

    task automatic test_reset_midstream;
        in_data = BAD; in_desc = 0; in_valid = 1; out_ready = 1;
        tick;
        in_valid = 0;
        tick;
        tests++;
        if (out_data !== 4'd3 || order_err !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre got d=%0d err=%b want 3/1", out_data, order_err);
        end
        rst_n = 0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || order_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst got v=%b err=%b want 0/0", out_valid, order_err);
        end
        tick;
        rst_n = 1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_release got r=%b v=%b want 1/0", in_ready, out_valid);
        end
        in_data = V1; in_desc = 0; in_valid = 1;
        tick;
        in_valid = 0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 4'd1) begin
            fails++;
            $display("FAIL mid_first got v=%b d=%0d want 1/1", out_valid, out_data);
        end
        tick;
        tests++;
        if (out_data !== 4'd3) begin
            fails++;
            $display("FAIL mid_second got d=%0d want 3", out_data);
        end
        repeat (4) tick;
    endtask

    initial begin
        test_reset;
        test_ascending;
        test_descending;
        test_back_to_back;
        test_backpressure;
        test_sort_check;
        test_reset_midstream;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
